// File: rtl/pc_sched_if.sv
// PC sequencing bus: PC register, instruction fetch port and redirect sources.
// Vectors are numbered MSB-first (bit 0 is the MSB).
interface pc_sched_if #(
    parameter int PC_WIDTH = 32
);
    logic [0:PC_WIDTH-1] pc;
    logic                pc_wr;
    logic [0:PC_WIDTH-1] npc;
    logic                fetch_req;
    logic [0:PC_WIDTH-1] fetch_addr;
    logic                fetch_ack;
    logic                fetch_discard;
    logic                stall;
    logic                br_valid;
    logic [0:PC_WIDTH-1] br_target;
    logic                rfi_valid;
    logic [0:PC_WIDTH-1] rfi_target;
    logic                exc_valid;
    logic [0:PC_WIDTH-1] exc_vec;
    logic                halt;
    logic                halted;

    // Scheduler side
    modport master (
        input  pc, fetch_ack, stall, br_valid, br_target, rfi_valid, rfi_target,
               exc_valid, exc_vec, halt,
        output pc_wr, npc, fetch_req, fetch_addr, fetch_discard, halted
    );

    // PC register / memory / branch-unit side
    modport slave (
        output pc, fetch_ack, stall, br_valid, br_target, rfi_valid, rfi_target,
               exc_valid, exc_vec, halt,
        input  pc_wr, npc, fetch_req, fetch_addr, fetch_discard, halted
    );
endinterface

// File: rtl/pc_sched.sv
// PC sequencing controller: next-PC arbitration, fetch handshake,
// redirect buffering across an in-flight fetch, and halt/wake.
module pc_sched #(
    parameter int                  PC_WIDTH   = 32,
    parameter logic [0:PC_WIDTH-1] RESET_VEC  = '0,
    parameter int                  INSN_BYTES = 4
) (
    input  logic         i_clk,
    input  logic         i_rst,
    pc_sched_if.master   bus
);
    typedef enum logic [1:0] {BOOT = 2'd0, RUN = 2'd1, HALT = 2'd2} state_t;

    // Redirect priority codes; larger wins
    localparam logic [1:0] PRI_BR  = 2'd0;
    localparam logic [1:0] PRI_RFI = 2'd1;
    localparam logic [1:0] PRI_EXC = 2'd2;

    state_t              r_state;
    logic                r_outstanding;
    logic                r_pend_valid;
    logic [0:PC_WIDTH-1] r_pend_tgt;
    logic [1:0]          r_pend_pri;

    state_t              w_state_nxt;
    logic                w_out_nxt;
    logic                w_pend_valid_nxt;
    logic [0:PC_WIDTH-1] w_pend_tgt_nxt;
    logic [1:0]          w_pend_pri_nxt;

    logic                w_fetch_req;
    logic [0:PC_WIDTH-1] w_seq;
    logic                w_new_valid;
    logic [0:PC_WIDTH-1] w_new_tgt;
    logic [1:0]          w_new_pri;
    logic                w_pc_wr;
    logic [0:PC_WIDTH-1] w_npc;
    logic                w_discard;

    // Sequential next PC, modulo 2^PC_WIDTH
    assign w_seq = bus.pc + PC_WIDTH'(INSN_BYTES);

    // Once raised, the request is held by r_outstanding until acked
    assign w_fetch_req = (r_state == RUN) & (r_outstanding | (!bus.stall & !bus.halt));

    // Pick this cycle's highest-priority redirect: exc > rfi > br
    always_comb begin
        w_new_valid = 1'b1;
        w_new_tgt   = bus.br_target;
        w_new_pri   = PRI_BR;
        if (bus.exc_valid) begin
            w_new_tgt = bus.exc_vec;
            w_new_pri = PRI_EXC;
        end else if (bus.rfi_valid) begin
            w_new_tgt = bus.rfi_target;
            w_new_pri = PRI_RFI;
        end else if (!bus.br_valid) begin
            w_new_valid = 1'b0;
        end
    end

    // Next-state, pending-redirect update and PC-write outputs
    always_comb begin
        w_state_nxt      = r_state;
        w_out_nxt        = r_outstanding;
        w_pend_valid_nxt = r_pend_valid;
        w_pend_tgt_nxt   = r_pend_tgt;
        w_pend_pri_nxt   = r_pend_pri;
        w_pc_wr          = 1'b0;
        w_npc            = w_seq;
        w_discard        = 1'b0;
        case (r_state)
            BOOT: begin
                w_state_nxt = RUN;
            end
            RUN: begin
                w_out_nxt = w_fetch_req & !bus.fetch_ack;
                if (!w_fetch_req) begin
                    // Nothing in flight: redirect goes straight to the PC
                    if (w_new_valid) begin
                        w_pc_wr = 1'b1;
                        w_npc   = w_new_tgt;
                    end
                    w_pend_valid_nxt = 1'b0;
                end else if (bus.fetch_ack) begin
                    w_pc_wr = 1'b1;
                    if (w_new_valid) begin
                        w_npc     = w_new_tgt;
                        w_discard = 1'b1;
                    end else if (r_pend_valid) begin
                        w_npc     = r_pend_tgt;
                        w_discard = 1'b1;
                    end
                    w_pend_valid_nxt = 1'b0;
                end else if (w_new_valid && (!r_pend_valid || w_new_pri >= r_pend_pri)) begin
                    // Fetch in flight: park the redirect until the ack
                    w_pend_valid_nxt = 1'b1;
                    w_pend_tgt_nxt   = w_new_tgt;
                    w_pend_pri_nxt   = w_new_pri;
                end
                if (bus.halt && !w_out_nxt) w_state_nxt = HALT;
            end
            HALT: begin
                // Only an exception wakes; br/rfi are ignored here
                if (bus.exc_valid) begin
                    w_pc_wr     = 1'b1;
                    w_npc       = bus.exc_vec;
                    w_state_nxt = RUN;
                end
            end
            default: begin
                w_state_nxt = BOOT;
            end
        endcase
    end

    // State and pending-redirect registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state       <= BOOT;
            r_outstanding <= 1'b0;
            r_pend_valid  <= 1'b0;
            r_pend_tgt    <= '0;
            r_pend_pri    <= PRI_BR;
        end else begin
            r_state       <= w_state_nxt;
            r_outstanding <= w_out_nxt;
            r_pend_valid  <= w_pend_valid_nxt;
            r_pend_tgt    <= w_pend_tgt_nxt;
            r_pend_pri    <= w_pend_pri_nxt;
        end
    end

    assign bus.pc_wr         = w_pc_wr;
    assign bus.npc           = w_npc;
    assign bus.fetch_req     = w_fetch_req;
    assign bus.fetch_addr    = bus.pc;
    assign bus.fetch_discard = w_discard;
    assign bus.halted        = (r_state == HALT);

    // The PC register must come out of reset at the same vector
    a_reset_vec: assert property (@(posedge i_clk) disable iff (i_rst)
        (r_state == BOOT) |-> (bus.pc == RESET_VEC));

endmodule

// File: tb/tb_pc_sched.sv
// Directed bench for pc_sched with a behavioural PC register.
module tb_pc_sched;
    localparam int          W    = 32;
    localparam logic [0:W-1] RVEC = 32'h0000_0100;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    pc_sched_if #(.PC_WIDTH(W)) bus ();

    pc_sched #(.PC_WIDTH(W), .RESET_VEC(RVEC), .INSN_BYTES(4)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // PC register model
    always_ff @(posedge clk or posedge rst) begin
        if (rst)             bus.pc <= RVEC;
        else if (bus.pc_wr)  bus.pc <= bus.npc;
    end

    // Advance to the next cycle's drive point with all strobes cleared
    task automatic nxt();
        @(negedge clk);
        bus.fetch_ack = 1'b0;
        bus.stall     = 1'b0;
        bus.halt      = 1'b0;
        bus.br_valid  = 1'b0;
        bus.rfi_valid = 1'b0;
        bus.exc_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.fetch_ack = 1'b0; bus.stall = 1'b0; bus.halt = 1'b0;
        bus.br_valid = 1'b0; bus.rfi_valid = 1'b0; bus.exc_valid = 1'b0;
        bus.br_target = '0; bus.rfi_target = '0; bus.exc_vec = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        bus.br_valid = 1'b1; bus.br_target = 32'h0000_0400;
        #1;
        if (bus.fetch_req !== 1'b0) begin errors++; $display("FAIL rst_req got %0b exp 0", bus.fetch_req); end
        checks++;
        if (bus.pc_wr !== 1'b0) begin errors++; $display("FAIL rst_pcwr got %0b exp 0", bus.pc_wr); end
        checks++;
        if (bus.halted !== 1'b0) begin errors++; $display("FAIL rst_halted got %0b exp 0", bus.halted); end
        checks++;
        bus.br_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        if (bus.fetch_req !== 1'b0) begin errors++; $display("FAIL boot_req got %0b exp 0", bus.fetch_req); end
        checks++;
    endtask

    task automatic test_boot_seq();
        logic [0:W-1] a;
        for (int i = 0; i < 3; i++) begin
            a = RVEC + 32'(4 * i);
            nxt(); bus.fetch_ack = 1'b1; #1;
            if (bus.fetch_req !== 1'b1 || bus.fetch_addr !== a) begin
                errors++; $display("FAIL boot_fetch%0d got req=%0b addr=%h exp req=1 addr=%h", i, bus.fetch_req, bus.fetch_addr, a);
            end
            checks++;
            if (bus.pc_wr !== 1'b1 || bus.npc !== a + 32'd4 || bus.fetch_discard !== 1'b0) begin
                errors++; $display("FAIL boot_npc%0d got wr=%0b npc=%h dis=%0b exp wr=1 npc=%h dis=0", i, bus.pc_wr, bus.npc, bus.fetch_discard, a + 32'd4);
            end
            checks++;
        end
    endtask

    task automatic test_redirect_hold();
        // Stalled, no request: branch to 0x200 applies at once
        nxt(); bus.stall = 1'b1; bus.br_valid = 1'b1; bus.br_target = 32'h0000_0200; #1;
        if (bus.fetch_req !== 1'b0 || bus.pc_wr !== 1'b1 || bus.npc !== 32'h0000_0200) begin
            errors++; $display("FAIL direct_br got req=%0b wr=%0b npc=%h exp req=0 wr=1 npc=00000200", bus.fetch_req, bus.pc_wr, bus.npc);
        end
        checks++;
        // Request to 0x200, branch to 0x400 arrives mid-flight
        nxt(); bus.br_valid = 1'b1; bus.br_target = 32'h0000_0400; #1;
        if (bus.fetch_req !== 1'b1 || bus.fetch_addr !== 32'h0000_0200 || bus.pc_wr !== 1'b0) begin
            errors++; $display("FAIL hold_c1 got req=%0b addr=%h wr=%0b exp req=1 addr=00000200 wr=0", bus.fetch_req, bus.fetch_addr, bus.pc_wr);
        end
        checks++;
        for (int i = 2; i < 4; i++) begin
            nxt(); bus.stall = 1'b1; #1;
            if (bus.fetch_req !== 1'b1 || bus.fetch_addr !== 32'h0000_0200 || bus.pc_wr !== 1'b0 || bus.fetch_discard !== 1'b0) begin
                errors++; $display("FAIL hold_c%0d got req=%0b addr=%h wr=%0b dis=%0b exp req=1 addr=00000200 wr=0 dis=0", i, bus.fetch_req, bus.fetch_addr, bus.pc_wr, bus.fetch_discard);
            end
            checks++;
        end
        nxt(); bus.stall = 1'b1; bus.fetch_ack = 1'b1; #1;
        if (bus.pc_wr !== 1'b1 || bus.npc !== 32'h0000_0400 || bus.fetch_discard !== 1'b1) begin
            errors++; $display("FAIL hold_ack got wr=%0b npc=%h dis=%0b exp wr=1 npc=00000400 dis=1", bus.pc_wr, bus.npc, bus.fetch_discard);
        end
        checks++;
        nxt(); bus.stall = 1'b1; #1;
        if (bus.fetch_req !== 1'b0 || bus.pc_wr !== 1'b0) begin
            errors++; $display("FAIL stall_noreq got req=%0b wr=%0b exp req=0 wr=0", bus.fetch_req, bus.pc_wr);
        end
        checks++;
        nxt(); bus.fetch_ack = 1'b1; #1;
        if (bus.fetch_addr !== 32'h0000_0400 || bus.npc !== 32'h0000_0404 || bus.fetch_discard !== 1'b0) begin
            errors++; $display("FAIL after_br got addr=%h npc=%h dis=%0b exp addr=00000400 npc=00000404 dis=0", bus.fetch_addr, bus.npc, bus.fetch_discard);
        end
        checks++;
    endtask

    task automatic test_priority();
        nxt(); bus.fetch_ack = 1'b1;
        bus.br_valid = 1'b1;  bus.br_target  = 32'h0000_0400;
        bus.rfi_valid = 1'b1; bus.rfi_target = 32'h0000_0500;
        bus.exc_valid = 1'b1; bus.exc_vec    = 32'h0000_0700;
        #1;
        if (bus.pc_wr !== 1'b1 || bus.npc !== 32'h0000_0700 || bus.fetch_discard !== 1'b1) begin
            errors++; $display("FAIL prio_all got wr=%0b npc=%h dis=%0b exp wr=1 npc=00000700 dis=1", bus.pc_wr, bus.npc, bus.fetch_discard);
        end
        checks++;
        nxt(); bus.fetch_ack = 1'b1; #1;
        if (bus.fetch_addr !== 32'h0000_0700 || bus.npc !== 32'h0000_0704 || bus.fetch_discard !== 1'b0) begin
            errors++; $display("FAIL prio_nopend got addr=%h npc=%h dis=%0b exp addr=00000700 npc=00000704 dis=0", bus.fetch_addr, bus.npc, bus.fetch_discard);
        end
        checks++;
    endtask

    task automatic test_pending();
        // Pending rfi survives a later lower-priority branch
        nxt(); bus.rfi_valid = 1'b1; bus.rfi_target = 32'h0000_0500; #1;
        if (bus.pc_wr !== 1'b0) begin errors++; $display("FAIL pend_rfi_wr got %0b exp 0", bus.pc_wr); end
        checks++;
        nxt(); bus.br_valid = 1'b1; bus.br_target = 32'h0000_0400; #1;
        nxt(); bus.fetch_ack = 1'b1; #1;
        if (bus.npc !== 32'h0000_0500 || bus.fetch_discard !== 1'b1 || bus.pc_wr !== 1'b1) begin
            errors++; $display("FAIL pend_rfi got npc=%h dis=%0b wr=%0b exp npc=00000500 dis=1 wr=1", bus.npc, bus.fetch_discard, bus.pc_wr);
        end
        checks++;
        // Pending branch replaced by a later exception
        nxt(); bus.br_valid = 1'b1; bus.br_target = 32'h0000_0400; #1;
        nxt(); bus.exc_valid = 1'b1; bus.exc_vec = 32'h0000_0700; #1;
        nxt(); bus.fetch_ack = 1'b1; #1;
        if (bus.npc !== 32'h0000_0700 || bus.fetch_discard !== 1'b1) begin
            errors++; $display("FAIL pend_exc got npc=%h dis=%0b exp npc=00000700 dis=1", bus.npc, bus.fetch_discard);
        end
        checks++;
        nxt(); bus.fetch_ack = 1'b1; #1;
        if (bus.npc !== 32'h0000_0704 || bus.fetch_discard !== 1'b0) begin
            errors++; $display("FAIL pend_clear got npc=%h dis=%0b exp npc=00000704 dis=0", bus.npc, bus.fetch_discard);
        end
        checks++;
    endtask

    task automatic test_halt();
        nxt(); #1;                       // request to 0x704 goes outstanding
        nxt(); bus.halt = 1'b1; #1;
        if (bus.fetch_req !== 1'b1 || bus.halted !== 1'b0) begin
            errors++; $display("FAIL halt_hold got req=%0b halted=%0b exp req=1 halted=0", bus.fetch_req, bus.halted);
        end
        checks++;
        nxt(); bus.halt = 1'b1; bus.fetch_ack = 1'b1; #1;
        if (bus.pc_wr !== 1'b1 || bus.npc !== 32'h0000_0708) begin
            errors++; $display("FAIL halt_ack got wr=%0b npc=%h exp wr=1 npc=00000708", bus.pc_wr, bus.npc);
        end
        checks++;
        for (int i = 0; i < 10; i++) begin
            nxt();
            bus.halt = (i < 6);
            bus.br_valid = (i >= 6); bus.br_target = 32'h0000_0400;
            bus.rfi_valid = (i == 8); bus.rfi_target = 32'h0000_0500;
            #1;
            if (bus.halted !== 1'b1 || bus.fetch_req !== 1'b0 || bus.pc_wr !== 1'b0) begin
                errors++; $display("FAIL halted_c%0d got halted=%0b req=%0b wr=%0b exp halted=1 req=0 wr=0", i, bus.halted, bus.fetch_req, bus.pc_wr);
            end
            checks++;
        end
        nxt(); bus.halt = 1'b1; bus.exc_valid = 1'b1; bus.exc_vec = 32'h0000_0700; #1;
        if (bus.pc_wr !== 1'b1 || bus.npc !== 32'h0000_0700) begin
            errors++; $display("FAIL wake got wr=%0b npc=%h exp wr=1 npc=00000700", bus.pc_wr, bus.npc);
        end
        checks++;
        nxt(); #1;
        if (bus.halted !== 1'b0 || bus.fetch_req !== 1'b1 || bus.fetch_addr !== 32'h0000_0700) begin
            errors++; $display("FAIL wake_fetch got halted=%0b req=%0b addr=%h exp halted=0 req=1 addr=00000700", bus.halted, bus.fetch_req, bus.fetch_addr);
        end
        checks++;
    endtask

    task automatic test_reset_mid();
        nxt(); #2;                       // request still outstanding
        rst = 1'b1; bus.fetch_ack = 1'b1;
        #1;
        if (bus.fetch_req !== 1'b0 || bus.pc_wr !== 1'b0 || bus.fetch_discard !== 1'b0 || bus.halted !== 1'b0) begin
            errors++; $display("FAIL rst_async got req=%0b wr=%0b dis=%0b halted=%0b exp all 0", bus.fetch_req, bus.pc_wr, bus.fetch_discard, bus.halted);
        end
        checks++;
        nxt(); rst = 1'b0; #1;
        if (bus.fetch_req !== 1'b0) begin errors++; $display("FAIL reboot_req got %0b exp 0", bus.fetch_req); end
        checks++;
        nxt(); bus.fetch_ack = 1'b1; #1;
        if (bus.fetch_req !== 1'b1 || bus.fetch_addr !== RVEC || bus.npc !== 32'h0000_0104) begin
            errors++; $display("FAIL reboot_fetch got req=%0b addr=%h npc=%h exp req=1 addr=00000100 npc=00000104", bus.fetch_req, bus.fetch_addr, bus.npc);
        end
        checks++;
    endtask

    task automatic test_wrap();
        nxt(); bus.stall = 1'b1; bus.br_valid = 1'b1; bus.br_target = 32'hFFFF_FFFC; #1;
        nxt(); bus.fetch_ack = 1'b1; #1;
        if (bus.fetch_addr !== 32'hFFFF_FFFC || bus.pc_wr !== 1'b1 || bus.npc !== 32'h0000_0000) begin
            errors++; $display("FAIL wrap got addr=%h wr=%0b npc=%h exp addr=fffffffc wr=1 npc=00000000", bus.fetch_addr, bus.pc_wr, bus.npc);
        end
        checks++;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_boot_seq();
        test_redirect_hold();
        test_priority();
        test_pending();
        test_halt();
        test_reset_mid();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pc_sched.md
Name: pc_sched

Overview:
- Sequencing controller for the program-counter register: produces its write enable and next-PC value, and runs the instruction-fetch request/acknowledge handshake.
- Arbitrates the next-PC sources: sequential, branch, return-from-interrupt and exception.
- Buffers redirects that arrive while a fetch is in flight, and supports halt/wake.
- Sits between the PC register, the instruction-memory port and the branch/exception units.

Parameters:
- PC_WIDTH, 32 (`PC_WIDTH): PC and address width. Bit 0 is the MSB, bit PC_WIDTH-1 the LSB.
- RESET_VEC, 0: PC value after reset. Must match the PC register reset value.
- INSN_BYTES, 4: sequential increment.

Ports:
- clk, in, 1: clock, rising edge.
- rst, in, 1: asynchronous, active-high reset.
- pc, in, PC_WIDTH: current PC-register output.
- pc_wr, out, 1: PC-register write enable.
- npc, out, PC_WIDTH: next PC to PC register.
- fetch_req, out, 1: instruction fetch request (level).
- fetch_addr, out, PC_WIDTH: fetch address (= pc).
- fetch_ack, in, 1: memory accepts/returns the current request.
- fetch_discard, out, 1: in an ack cycle, the returned instruction is wrong-path.
- stall, in, 1: downstream cannot take a new instruction.
- br_valid, in, 1: taken-branch redirect.
- br_target, in, PC_WIDTH: branch target.
- rfi_valid, in, 1: return from interrupt.
- rfi_target, in, PC_WIDTH: saved return PC (SRR0).
- exc_valid, in, 1: exception/interrupt entry; also the wake source from HALT.
- exc_vec, in, PC_WIDTH: exception vector.
- halt, in, 1: halt request (level).
- halted, out, 1: state == HALT.

Behaviour:
- States: BOOT, RUN, HALT, encoded 2 bits.
- Reset (asynchronous, any time including mid-request):
  - state=BOOT, outstanding=0, pend_valid=0.
  - Outputs: pc_wr=0, fetch_req=0, fetch_discard=0, halted=0.
  - An in-flight request is abandoned; the memory side is reset by the same rst.
- BOOT: lasts exactly one cycle with fetch_req=0, then → RUN.
- fetch_req = (state==RUN) & (outstanding | (!stall & !halt)).
  - outstanding sets when fetch_req & !fetch_ack; it clears on ack.
  - Once raised, fetch_req holds until ack regardless of stall, halt or redirect. fetch_addr stays stable for the whole request.
- Redirect source priority: exc > rfi > br. The highest-priority valid input in a cycle is the "new redirect". The effective redirect is the new redirect if present, else the pending one.
- Redirect timing:
  - fetch_req low in that cycle: apply immediately. pc_wr=1, npc=target, no discard.
  - fetch_req high, no ack: store in pending (pend_valid, pend_tgt, pend_pri). A new redirect of higher or equal priority overwrites it; a lower-priority one is dropped. pc_wr=0.
  - fetch_req high with ack: pc_wr=1, npc=effective redirect target, fetch_discard=1, pending cleared.
- Ack with no redirect (new or pending): pc_wr=1, npc=pc+INSN_BYTES, discard=0.
- Default (no ack, no applicable redirect): pc_wr=0, npc=pc+INSN_BYTES.
- Arithmetic: pc+INSN_BYTES is modulo 2^PC_WIDTH, so all-ones minus 3 wraps to 0. Targets pass through unmodified.
- Halt:
  - In RUN with halt=1: no new request issues. Once outstanding=0 (after the final ack is processed) → HALT.
  - Any pending redirect is applied on the final ack as above.
  - A redirect applied with fetch_req low in the entry cycle still writes the PC.
  - In HALT: fetch_req=0. br and rfi are ignored. exc_valid → pc_wr=1, npc=exc_vec, next state RUN; this wakes even if halt is still high.
  - halt deasserting while in HALT without exc does not wake.
- fetch_discard is 0 whenever fetch_ack=0.

Test Plan:
- Boot, RESET_VEC=0x100, stall=0, ack in the same cycle as each request:
  - fetch_req=0 in the first cycle after rst falls.
  - Requests then go to 0x100, 0x104, 0x108, with pc_wr=1 each ack cycle and npc one step ahead.
- Request to 0x200 held 3 cycles without ack; br_valid pulse (0x400) in cycle 1, then stall=1:
  - fetch_req and fetch_addr=0x200 stay stable.
  - On ack: pc_wr=1, npc=0x400, fetch_discard=1.
  - No new request while stall=1.
- Same cycle: br_valid(0x400), rfi_valid(0x500), exc_valid(0x700) with ack → npc=0x700, discard=1. The pending register is left empty: the next plain ack gives npc=pc+4.
- Pending rfi(0x500), then a later br(0x400) before ack → ack gives npc=0x500. Pending br, then a later exc → ack gives npc=exc_vec.
- halt=1 while request outstanding:
  - The ack completes; halted=1 next cycle; fetch_req stays 0 for 10 cycles.
  - exc_valid(0x700) → pc_wr=1, npc=0x700, halted=0, and the next request goes to 0x700.
- Assert rst during an outstanding request:
  - All outputs zero immediately, with no clock edge needed.
  - After release: BOOT cycle, then fetch from RESET_VEC.
- pc=0xFFFFFFFC with ack → npc=0x00000000.
